imm_encoder: RTL and testbench

Pipelined immediate encoder: the inverse of the decode-stage immediate extender. It takes a base instruction word, a 32-bit immediate and the shared 3-bit immediate-select code, scatters the immediate into that format's instruction bit positions, and emits the finished word with a word-aligned write address. It sits in the program-loader / self-test path, feeding instruction memory, and uses valid/ready handshakes on both sides.

---
 rtl/imm_encoder_pkg.sv | 23 ++
 rtl/imm_encoder_scatter.sv | 78 +++++++
 rtl/imm_encoder.sv | 113 +++++++++++
 tb/tb_imm_encoder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format codes, error codes and range helper for the immediate encoder.
package imm_encoder_pkg;

  localparam logic [2:0] IMM_U   = 3'b000;
  localparam logic [2:0] IMM_I   = 3'b001;
  localparam logic [2:0] IMM_ISH = 3'b010;
  localparam logic [2:0] IMM_S   = 3'b011;
  localparam logic [2:0] IMM_B   = 3'b100;
  localparam logic [2:0] IMM_J   = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_RANGE    = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  // True when v[31:msb] are all equal, i.e. v fits a signed field whose sign bit is msb.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic signed [31:0] s;
    s = $signed(v) >>> msb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_scatter.sv
// Combinational immediate scatter and error detection for one instruction word.
// Range/misalignment checks are present only when IMM_RANGE_CHECK_EN is defined.
module imm_scatter
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  i_sel,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_base,
  output logic [31:0] o_instr,
  output logic [1:0]  o_err
);

  logic w_illegal;
  logic w_range;
  logic w_misalign;

`ifdef IMM_RANGE_CHECK_EN
  always_comb begin
    w_range    = 1'b0;
    w_misalign = 1'b0;
    case (i_sel)
      IMM_U:        w_range = |i_imm[11:0];
      IMM_I, IMM_S: w_range = !fits_signed(i_imm, 11);
      IMM_ISH:      w_range = |i_imm[31:6];
      IMM_B: begin
        w_range    = !fits_signed(i_imm, 12);
        w_misalign = i_imm[0];
      end
      IMM_J: begin
        w_range    = !fits_signed(i_imm, 20);
        w_misalign = i_imm[0];
      end
      default: ;
    endcase
  end
`else
  assign w_range    = 1'b0;
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    o_instr   = i_base;
    w_illegal = 1'b0;
    case (i_sel)
      IMM_U: o_instr[31:12] = i_imm[31:12];
      IMM_I: o_instr[31:20] = i_imm[11:0];
      IMM_ISH: begin
        o_instr[31]    = 1'b0;
        o_instr[30]    = i_imm[5];
        o_instr[29:25] = 5'b0;
        o_instr[24:20] = i_imm[4:0];
      end
      IMM_S: begin
        o_instr[31:25] = i_imm[11:5];
        o_instr[11:7]  = i_imm[4:0];
      end
      IMM_B: begin
        o_instr[31]    = i_imm[12];
        o_instr[30:25] = i_imm[10:5];
        o_instr[11:8]  = i_imm[4:1];
        o_instr[7]     = i_imm[11];
      end
      IMM_J: begin
        o_instr[31]    = i_imm[20];
        o_instr[30:21] = i_imm[10:1];
        o_instr[20]    = i_imm[11];
        o_instr[19:12] = i_imm[19:12];
      end
      default: w_illegal = 1'b1;
    endcase

    if (w_illegal)       o_err = ERR_ILLEGAL;
    else if (w_misalign) o_err = ERR_MISALIGN;
    else if (w_range)    o_err = ERR_RANGE;
    else                 o_err = ERR_OK;
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage pipelined immediate encoder with valid/ready handshakes and a word address counter.
// Optional range/misalignment checking is enabled by defining IMM_RANGE_CHECK_EN.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          imm_select,
  input  logic [31:0]         imm_value,
  input  logic [31:0]         base_instr,
  input  logic                addr_load,
  input  logic [ADDR_W-1:0]   addr_load_val,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [1:0]          out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  logic                r_a_valid;
  logic [2:0]          r_a_sel;
  logic [31:0]         r_a_imm;
  logic [31:0]         r_a_base;
  logic                r_b_valid;
  logic [31:0]         r_out_instr;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [1:0]          r_out_err;
  logic [ADDR_W-1:0]   r_next_addr;
  logic [ERRCNT_W-1:0] r_err_count;

  logic                w_b_can_load;
  logic                w_b_take;
  logic                w_in_fire;
  logic                w_out_fire;
  logic [31:0]         w_enc_instr;
  logic [1:0]          w_enc_err;
  logic [ADDR_W-1:0]   w_load_addr;
  logic [ADDR_W-1:0]   w_word_addr;

  assign w_b_can_load = !r_b_valid || out_ready;
  assign in_ready     = !r_a_valid || w_b_can_load;
  assign w_in_fire    = in_valid && in_ready;
  assign w_b_take     = w_b_can_load && r_a_valid;
  assign w_out_fire   = r_b_valid && out_ready;
  assign w_load_addr  = addr_load_val & ~ADDR_W'(3);
  assign w_word_addr  = addr_load ? w_load_addr : r_next_addr;

  imm_scatter u_scatter (
    .i_sel   (r_a_sel),
    .i_imm   (r_a_imm),
    .i_base  (r_a_base),
    .o_instr (w_enc_instr),
    .o_err   (w_enc_err)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_a_valid <= 1'b0;
      r_a_sel   <= 3'b0;
      r_a_imm   <= 32'b0;
      r_a_base  <= 32'b0;
    end else begin
      if (in_ready) r_a_valid <= in_valid;
      if (w_in_fire) begin
        r_a_sel  <= imm_select;
        r_a_imm  <= imm_value;
        r_a_base <= base_instr;
      end
    end
  end

  // Output data only changes when a new word is taken, so it holds under backpressure.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_b_valid   <= 1'b0;
      r_out_instr <= 32'b0;
      r_out_addr  <= '0;
      r_out_err   <= ERR_OK;
      r_next_addr <= '0;
    end else begin
      if (w_b_can_load) r_b_valid <= r_a_valid;
      if (w_b_take) begin
        r_out_instr <= w_enc_instr;
        r_out_err   <= w_enc_err;
        r_out_addr  <= w_word_addr;
        r_next_addr <= w_word_addr + ADDR_W'(4);
      end else if (addr_load) begin
        r_next_addr <= w_load_addr;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_err_count <= '0;
    end else if (w_out_fire && (r_out_err != ERR_OK) && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERRCNT_W'(1);
    end
  end

  assign out_valid = r_b_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed literal cases plus randomized traffic
// checked against a field-mask reference model. Honours IMM_RANGE_CHECK_EN.
module tb_imm_encoder;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  imm_select = '0;
  logic [31:0] imm_value = '0;
  logic [31:0] base_instr = '0;
  logic        addr_load = 1'b0;
  logic [31:0] addr_load_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [1:0]  out_err;
  logic [7:0]  err_count;

  imm_encoder #(.ADDR_W(32), .ERRCNT_W(8)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .imm_select    (imm_select),
    .imm_value     (imm_value),
    .base_instr    (base_instr),
    .addr_load     (addr_load),
    .addr_load_val (addr_load_val),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_addr      (out_addr),
    .out_err       (out_err),
    .err_count     (err_count)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: splice a field into the base word through a format mask.
  function automatic void model(input logic [2:0] sel, input logic [31:0] imm,
                                input logic [31:0] base, output logic [31:0] instr,
                                output logic [1:0] err);
    logic [31:0] mask, field;
    int signed   s;
    bit          rng, mis, ill;
    s = $signed(imm);
    rng = 0; mis = 0; ill = 0; mask = 0; field = 0;
    case (sel)
      3'd0: begin mask = 32'hFFFFF000; field = imm; rng = (imm % 4096) != 0; end
      3'd1: begin mask = 32'hFFF00000; field = imm << 20; rng = (s < -2048) || (s > 2047); end
      3'd2: begin
        mask  = 32'hFFF00000;
        field = ((imm & 32'h1F) << 20) | (((imm >> 5) & 1) << 30);
        rng   = imm >= 64;
      end
      3'd3: begin
        mask  = 32'hFE000F80;
        field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        rng   = (s < -2048) || (s > 2047);
      end
      3'd4: begin
        mask  = 32'hFE000F80;
        field = (((imm >> 12) & 1) << 31) | (((imm >> 11) & 1) << 7) |
                (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8);
        rng   = (s < -4096) || (s > 4095);
        mis   = imm[0];
      end
      3'd5: begin
        mask  = 32'hFFFFF000;
        field = (((imm >> 20) & 1) << 31) | (((imm >> 12) & 32'hFF) << 12) |
                (((imm >> 11) & 1) << 20) | (((imm >> 1) & 32'h3FF) << 21);
        rng   = (s < -(1 << 20)) || (s >= (1 << 20));
        mis   = imm[0];
      end
      default: ill = 1;
    endcase
`ifndef IMM_RANGE_CHECK_EN
    rng = 0;
    mis = 0;
`endif
    instr = (base & ~mask) | (field & mask);
    err = ill ? 2'b11 : mis ? 2'b10 : rng ? 2'b01 : 2'b00;
  endfunction

  logic [31:0] q_instr[$], q_addr[$];
  logic [1:0]  q_err[$];
  int          q_hs[$];
  logic [31:0] h_instr[$], h_addr[$];
  logic [1:0]  h_err[$];
  int          h_cyc[$], h_lat[$];
  int          cyc = 0;
  logic [31:0] m_next = 0;
  int          m_cnt = 0;
  bit          prev_stall = 0;
  logic [31:0] p_instr, p_addr;
  logic [1:0]  p_err;

  // Single compare process: samples on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    logic [31:0] e_instr;
    logic [1:0]  e_err;
    cyc++;
    if (RESET) begin
      q_instr.delete(); q_addr.delete(); q_err.delete(); q_hs.delete();
      m_cnt = 0; m_next = 0; prev_stall = 0;
    end else begin
      check("err_count", err_count, m_cnt);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_instr", out_instr, p_instr);
        check("hold_addr", out_addr, p_addr);
        check("hold_err", out_err, p_err);
      end
      if (out_valid && out_ready) begin
        if (q_instr.size() == 0) begin
          check("unexpected_output", out_valid, 0);
        end else begin
          check("out_instr", out_instr, q_instr[0]);
          check("out_addr", out_addr, q_addr[0]);
          check("out_err", out_err, q_err[0]);
          if (q_err[0] != 2'b00 && m_cnt < 255) m_cnt++;
          h_instr.push_back(out_instr); h_addr.push_back(out_addr); h_err.push_back(out_err);
          h_cyc.push_back(cyc); h_lat.push_back(cyc - q_hs[0]);
          void'(q_instr.pop_front()); void'(q_addr.pop_front());
          void'(q_err.pop_front()); void'(q_hs.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        model(imm_select, imm_value, base_instr, e_instr, e_err);
        q_instr.push_back(e_instr); q_addr.push_back(m_next); q_err.push_back(e_err);
        q_hs.push_back(cyc);
        m_next += 4;
      end else if (addr_load) begin
        m_next = addr_load_val & ~32'd3;
      end
      prev_stall = out_valid && !out_ready;
      p_instr = out_instr; p_addr = out_addr; p_err = out_err;
    end
  end

  bit rand_en = 0;
  always @(posedge CLK) begin
    if (rand_en) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
    int k;
    in_valid = 1; imm_select = sel; imm_value = imm; base_instr = base;
    k = 0;
    forever begin
      @(negedge CLK);
      if (in_ready) break;
      k++;
      if (k > 500) begin
        check("send_timeout", in_ready, 1);
        break;
      end
    end
    @(posedge CLK); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q_instr.size() != 0 && k < 500) begin
      @(posedge CLK); #1;
      k++;
    end
    if (q_instr.size() != 0) check("drain_timeout", q_instr.size(), 0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RESET = 1;
    repeat (2) @(posedge CLK);
    #1 RESET = 0;
  endtask

  int h;
  logic [7:0] e_cnt;
  logic [1:0] e_ierr, e_berr;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_err", out_err, 0);
    check("rst_err_count", err_count, 0);
    RESET = 0;
    #1 check("rst_in_ready", in_ready, 1);
    @(posedge CLK); #1;

    // I format with latency check
    h = h_instr.size();
    send(3'b001, 32'hFFFFFFFF, 32'h00000093);
    drain();
    check("i_instr", h_instr[h], 32'hFFF00093);
    check("i_err", h_err[h], 0);
    check("i_addr", h_addr[h], 0);
    check("i_latency", h_lat[h], 2);

    // S then B back to back
    do_reset();
    h = h_instr.size();
    send(3'b011, 32'd8, 32'h0020A023);
    send(3'b100, 32'hFFFFFFFC, 32'h00000063);
    drain();
    check("s_instr", h_instr[h], 32'h0020A423);
    check("s_addr", h_addr[h], 0);
    check("b_instr", h_instr[h+1], 32'hFE000EE3);
    check("b_addr", h_addr[h+1], 4);
    check("sb_no_bubble", h_cyc[h+1] - h_cyc[h], 1);

    // addr_load alone, then J and U
    addr_load = 1; addr_load_val = 32'h1003;
    @(posedge CLK); #1 addr_load = 0;
    h = h_instr.size();
    send(3'b101, 32'h800, 32'h000000EF);
    send(3'b000, 32'h12345000, 32'h000002B7);
    drain();
    check("j_instr", h_instr[h], 32'h001000EF);
    check("j_addr", h_addr[h], 32'h1000);
    check("u_instr", h_instr[h+1], 32'h123452B7);
    check("u_addr", h_addr[h+1], 32'h1004);

    // Error codes
`ifdef IMM_RANGE_CHECK_EN
    e_ierr = 2'b01; e_berr = 2'b10; e_cnt = 3;
`else
    e_ierr = 2'b00; e_berr = 2'b00; e_cnt = 1;
`endif
    do_reset();
    h = h_instr.size();
    send(3'b001, 32'd2048, 32'h00000013);
    send(3'b100, 32'd3, 32'h00000063);
    send(3'b111, 32'h0000ABCD, 32'hDEADBEEF);
    drain();
    check("err_i", h_err[h], e_ierr);
    check("err_b", h_err[h+1], e_berr);
    check("err_ill", h_err[h+2], 2'b11);
    check("ill_instr", h_instr[h+2], 32'hDEADBEEF);
    check("err_count_total", err_count, e_cnt);

    // Backpressure
    out_ready = 0;
    h = h_instr.size();
    send(3'b001, 32'd1, 32'h00000013);
    send(3'b001, 32'd2, 32'h00000013);
    in_valid = 1; imm_select = 3'b001; imm_value = 32'd3; base_instr = 32'h00000013;
    repeat (3) @(negedge CLK);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_accepted", q_instr.size(), 2);
    @(posedge CLK); #1 out_ready = 1;
    send(3'b001, 32'd3, 32'h00000013);
    drain();
    check("bp_instr0", h_instr[h], 32'h00100013);
    check("bp_instr2", h_instr[h+2], 32'h00300013);
    check("bp_addr_step1", h_addr[h+1] - h_addr[h], 4);
    check("bp_addr_step2", h_addr[h+2] - h_addr[h+1], 4);

    // Reset with both stages full
    out_ready = 0;
    send(3'b000, 32'h0, 32'h00000037);
    send(3'b000, 32'h1000, 32'h00000037);
    @(negedge CLK);
    check("mid_pre_valid", out_valid, 1);
    @(posedge CLK); #1 RESET = 1;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_err_count", err_count, 0);
    repeat (2) @(posedge CLK);
    #1 RESET = 0; out_ready = 1;
    @(posedge CLK); #1;
    h = h_instr.size();
    send(3'b001, 32'd5, 32'h00000013);
    drain();
    check("mid_next_addr", h_addr[h], 0);
    check("mid_count_out", h_instr.size() - h, 1);

    // Randomized traffic
    rand_en = 1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = $urandom_range(0, 8191) - 4096;
        2: imm = $urandom_range(0, 127);
        default: imm = $urandom & 32'hFFFFF000;
      endcase
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #0 send(3'($urandom_range(0, 7)), imm, $urandom);
    end
    rand_en = 0;
    @(posedge CLK); #2 out_ready = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
